// File: rtl/demux_dispatch4.sv
// rtl/demux_dispatch4.sv - single-entry demultiplexer dispatching one upstream stream to four channels
// Round-robin over enabled channels or fixed-channel routing, one holding register, dispatch counter.

module demux_dispatch4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [1:0]       cfg_sel,
    input  logic [3:0]       en_mask,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       sel,
    output logic [7:0]       disp_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] hold_data;
    logic             hold_fixed;
    logic [1:0]       ptr;
    logic [1:0]       ptr_nxt;
    logic [1:0]       tgt;
    logic [1:0]       cand;
    logic             rr_found;
    logic             dispatch;
    logic             accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dispatch  = (state == FULL) && out_ready[sel];
        in_ready  = (state == EMPTY) || out_ready[sel];
        if (!mode && (en_mask == 4'b0000)) begin
            in_ready = 1'b0;
        end
        accept = in_valid && in_ready;

        // A same-cycle refill searches from the pointer as already advanced by this dispatch.
        ptr_nxt = (dispatch && !hold_fixed) ? sel + 2'd1 : ptr;

        tgt      = ptr_nxt;
        cand     = ptr_nxt;
        rr_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_nxt + 2'(i);
            if (!rr_found && en_mask[cand]) begin
                tgt      = cand;
                rr_found = 1'b1;
            end
        end
        if (mode) begin
            tgt = cfg_sel;
        end

        case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (dispatch && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase

        out_valid = (state == FULL) ? (4'b0001 << sel) : 4'b0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data  <= '0;
            hold_fixed <= 1'b0;
            sel        <= 2'd0;
            ptr        <= 2'd0;
            disp_cnt   <= 8'd0;
        end else begin
            ptr <= ptr_nxt;
            if (dispatch) begin
                disp_cnt <= disp_cnt + 8'd1;
            end
            if (accept) begin
                hold_data  <= in_data;
                hold_fixed <= mode;
                sel        <= tgt;
            end
        end
    end

    assign out_data = hold_data;

endmodule

// File: tb/tb_demux_dispatch4.sv
// tb/tb_demux_dispatch4.sv - randomized and directed bench for demux_dispatch4 with a behavioural model
// Model is checked every falling edge; directed sections pin literal expectations.

module tb_demux_dispatch4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       mode;
    logic [1:0] cfg_sel;
    logic [3:0] en_mask;
    logic [7:0] out_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [1:0] sel;
    logic [7:0] disp_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // behavioural model state
    bit m_full;
    int m_data;
    int m_tgt;
    bit m_fixed;
    int m_ptr;
    int m_cnt;

    demux_dispatch4 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .cfg_sel   (cfg_sel),
        .en_mask   (en_mask),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .disp_cnt  (disp_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int rr_pick(input int p, input logic [3:0] em);
        for (int k = 0; k < 4; k++) begin
            if (em[(p + k) % 4]) return (p + k) % 4;
        end
        return 0;
    endfunction

    always @(negedge clk) begin
        bit hs;
        bit exp_rdy;
        if (rst) begin
            m_full = 0; m_data = 0; m_tgt = 0; m_fixed = 0; m_ptr = 0; m_cnt = 0;
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_out_data", int'(out_data), 0);
            chk("rst_sel", int'(sel), 0);
            chk("rst_disp_cnt", int'(disp_cnt), 0);
        end else begin
            chk("out_valid", int'(out_valid), m_full ? (1 << m_tgt) : 0);
            if (m_full) chk("out_data", int'(out_data), m_data);
            chk("sel", int'(sel), m_tgt);
            chk("disp_cnt", int'(disp_cnt), m_cnt);
            hs      = m_full && out_ready[m_tgt];
            exp_rdy = (!m_full || hs) && !(!mode && en_mask == 4'b0000);
            chk("in_ready", int'(in_ready), int'(exp_rdy));
            if (hs) begin
                m_cnt  = (m_cnt + 1) % 256;
                m_full = 0;
                if (!m_fixed) m_ptr = (m_tgt + 1) % 4;
            end
            if (in_valid && exp_rdy) begin
                m_full  = 1;
                m_data  = int'(in_data);
                m_fixed = mode;
                m_tgt   = mode ? int'(cfg_sel) : rr_pick(m_ptr, en_mask);
            end
        end
    end

    task automatic step(input bit v, input logic [7:0] d, input bit m, input logic [1:0] cs,
                        input logic [3:0] em, input logic [3:0] ordy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        mode      = m;
        cfg_sel   = cs;
        en_mask   = em;
        out_ready = ordy;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_disp_cnt", int'(disp_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        mode      = 1'b0;
        cfg_sel   = 2'd0;
        en_mask   = 4'b1111;
        out_ready = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // round-robin sweep over all four channels
        for (int i = 0; i < 6; i++) begin
            step(i < 5, 8'(8'h11 * (i + 1)), 1'b0, 2'd0, 4'b1111, 4'b1111);
            #1;
            if (i > 0) begin
                chk("rr_sweep_valid", int'(out_valid), 1 << ((i - 1) % 4));
                chk("rr_sweep_data", int'(out_data), 8'h11 * i);
                chk("rr_sweep_ready", int'(in_ready), 1);
            end
        end
        step(1'b0, 8'h00, 1'b0, 2'd0, 4'b1111, 4'b1111);
        #1;
        chk("rr_sweep_cnt", int'(disp_cnt), 5);

        // skip disabled channels; pointer is at 1 here
        for (int i = 0; i < 5; i++) begin
            step(i < 4, 8'(8'hA0 + i), 1'b0, 2'd0, 4'b1010, 4'b1111);
            #1;
            if (i > 0) chk("skip_valid", int'(out_valid), (i % 2) ? 4'b0010 : 4'b1000);
        end
        step(1'b1, 8'hEE, 1'b0, 2'd0, 4'b0000, 4'b1111);
        #1;
        chk("mask0_ready", int'(in_ready), 0);
        step(1'b0, 8'h00, 1'b0, 2'd0, 4'b0000, 4'b1111);
        #1;
        chk("mask0_no_accept", int'(out_valid), 0);

        // backpressure on channel 2, then same-cycle refill
        do_reset();
        step(1'b1, 8'hA5, 1'b0, 2'd0, 4'b0100, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h5A, 1'b0, 2'd0, 4'b1111, 4'b1011);
            #1;
            chk("bp_valid", int'(out_valid), 4'b0100);
            chk("bp_data", int'(out_data), 8'hA5);
            chk("bp_ready", int'(in_ready), 0);
        end
        step(1'b1, 8'h5A, 1'b0, 2'd0, 4'b1111, 4'b0100);
        #1;
        chk("bp_refill_ready", int'(in_ready), 1);
        step(1'b0, 8'h00, 1'b0, 2'd0, 4'b1111, 4'b0000);
        #1;
        chk("bp_next_ch3", int'(out_valid), 4'b1000);
        chk("bp_next_data", int'(out_data), 8'h5A);

        // fixed mode to channel 2; RR resumes from ptr 0 afterwards
        for (int i = 0; i < 4; i++) begin
            step(i < 3, 8'(8'hC0 + i), 1'b1, 2'd2, 4'b0001, 4'b1111);
            #1;
            if (i > 0) chk("fixed_valid", int'(out_valid), 4'b0100);
        end
        step(1'b1, 8'hD0, 1'b0, 2'd0, 4'b1111, 4'b1111);
        step(1'b0, 8'h00, 1'b0, 2'd0, 4'b1111, 4'b1111);
        #1;
        chk("fixed_resume_ch0", int'(out_valid), 4'b0001);

        // counter wrap after 256 dispatches
        do_reset();
        for (int i = 0; i < 256; i++) step(1'b1, 8'(i), 1'b1, 2'd0, 4'b1111, 4'b1111);
        step(1'b0, 8'h00, 1'b1, 2'd0, 4'b1111, 4'b1111);
        #1;
        chk("wrap_255", int'(disp_cnt), 255);
        step(1'b0, 8'h00, 1'b1, 2'd0, 4'b1111, 4'b1111);
        #1;
        chk("wrap_0", int'(disp_cnt), 0);

        // reset while full; first post-reset payload goes to ch0
        step(1'b1, 8'h77, 1'b1, 2'd3, 4'b1111, 4'b0000);
        step(1'b0, 8'h00, 1'b0, 2'd0, 4'b1111, 4'b0000);
        do_reset();
        step(1'b1, 8'h99, 1'b0, 2'd0, 4'b1111, 4'b0000);
        step(1'b0, 8'h00, 1'b0, 2'd0, 4'b1111, 4'b0000);
        #1;
        chk("post_rst_ch0", int'(out_valid), 4'b0001);
        chk("post_rst_cnt", int'(disp_cnt), 0);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
                 2'($urandom), ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom),
                 4'($urandom));
            if ($urandom_range(0, 299) == 0) do_reset();
        end
        step(1'b0, 8'h00, 1'b0, 2'd0, 4'b1111, 4'b1111);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux_dispatch4.md
DEMUX_DISPATCH4 -- requirements
Module: demux_dispatch4

Interface
REQ-001 Parameter: WIDTH, 8, payload width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 in_data  input  WIDTH  payload from the single upstream source.
REQ-005 in_valid  input  1  upstream payload valid.
REQ-006 in_ready  output  1  block can accept a payload this cycle.
REQ-007 mode  input  1  0 = round-robin dispatch; 1 = fixed channel via cfg_sel.
REQ-008 cfg_sel  input  2  target channel in fixed mode.
REQ-009 en_mask  input  4  per-channel enable for round-robin mode; bit i enables channel i.
REQ-010 out_data  output  WIDTH  shared payload bus to all four channels.
REQ-011 out_valid  output  4  one-hot valid; bit i set means payload is for channel i.
REQ-012 out_ready  input  4  per-channel consumer ready.
REQ-013 sel  output  2  index of the channel currently held or last dispatched.
REQ-014 disp_cnt  output  8  count of completed dispatches.

Function
REQ-015 The block SHALL contain one holding register (data plus target) and a two-state FSM: EMPTY, FULL.
REQ-016 In EMPTY, out_valid SHALL be 4'b0000.
REQ-017 In FULL, out_valid SHALL be one-hot at bit sel.
REQ-018 In FULL, out_data SHALL equal the held payload, stable until handshake.
REQ-019 in_ready SHALL be combinational: 1 when EMPTY, or when FULL and out_ready[sel]=1 (same-cycle refill).
REQ-020 In round-robin mode with en_mask=4'b0000, in_ready SHALL be 0 regardless of REQ-019.
REQ-021 Accept occurs when in_valid and in_ready are both 1; the held payload SHALL appear on out_data/out_valid the next cycle (latency 1).
REQ-022 Target in round-robin mode is the first enabled channel searching ptr, ptr+1, ... modulo 4, where ptr is the 2-bit round-robin pointer.
REQ-023 Target in fixed mode SHALL equal cfg_sel; en_mask is ignored.
REQ-024 mode, cfg_sel and en_mask SHALL be sampled only at accept; changes while FULL SHALL NOT alter the held target.
REQ-025 Dispatch handshake occurs when FULL and out_ready[sel]=1.
REQ-026 On dispatch handshake, disp_cnt SHALL increment by 1, wrapping 255 to 0.
REQ-027 On dispatch handshake in round-robin mode, ptr SHALL become (sel+1) mod 4, wrapping 3 to 0.
REQ-028 On dispatch handshake in fixed mode, ptr SHALL be unchanged.
REQ-029 Transition FULL->EMPTY SHALL occur on dispatch handshake without accept.
REQ-030 Transition FULL->FULL with the new payload and a freshly computed target SHALL occur on simultaneous handshake and accept.
REQ-031 Transition EMPTY->FULL SHALL occur on accept.
REQ-032 The pointer used for a simultaneous accept SHALL be the post-update value of REQ-027.
REQ-033 out_ready bits other than sel SHALL have no effect.
REQ-034 The FSM SHALL stay FULL indefinitely while out_ready[sel]=0 (no timeout, no drop).

Reset
REQ-035 While rst=1, asynchronously: state=EMPTY, out_valid=4'b0000, out_data=0, sel=0, ptr=0, disp_cnt=0.
REQ-036 Reset mid-operation SHALL discard the held payload; that payload SHALL NOT be counted.
REQ-037 First edge after rst deasserts SHALL behave as EMPTY.

Verification
REQ-038 RR sweep: mode=0, en_mask=1111, out_ready=1111, in_valid=1 for 5 payloads 0x11..0x55 -> out_valid 0001,0010,0100,1000,0001 on consecutive cycles; disp_cnt=5; in_ready stays 1.
REQ-039 Skip: mode=0, en_mask=1010, 4 payloads -> channels 1,3,1,3; with en_mask=0000 -> in_ready=0, no accept.
REQ-040 Backpressure: FULL to ch2 with out_ready=0000 for 3 cycles -> out_valid=0100, out_data stable, in_ready=0; out_ready=0100 with in_valid=1 -> same-cycle accept, next target ch3.
REQ-041 Fixed mode: mode=1, cfg_sel=2, 3 payloads -> all on out_valid=0100; ptr unchanged; switching to mode=0 resumes from prior ptr.
REQ-042 Wrap: 256 dispatches -> disp_cnt returns to 0.
REQ-043 Reset: assert rst while FULL -> out_valid=0000 immediately (before next edge); disp_cnt=0; first post-reset payload goes to ch0.
